fifo_wr_arb: RTL

- Round-robin write arbiter that shares one 8-entry synchronous FIFO (depth 8, 8-bit data, wsig/full write interface) among NREQ producers.
- Grants one producer at a time for a burst of up to BURST words, then drives the FIFO write port directly.
- Honours FIFO back-pressure, so no word is ever offered while the FIFO is full.
- Sits between producer blocks and the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arb_rr_pick.sv | 32 +++
 rtl/fifo_wr_arb.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter family.
// No logic; pure declarations.
// Imported by the arbiter top and the round-robin picker.
package fifo_arb_pkg;

  // Arbiter control states
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } fsm_e;

  localparam int NREQ_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int BURST_DEF = 4;

  // Width of a producer index (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-grant word counter; must hold the value BURST
  function automatic int cnt_w(input int b);
    return $clog2(b) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin priority picker: first set request after 'last', wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; callers decide when to sample the winner.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   win,
  output logic            any_req
);

  // Scan from farthest to nearest so the nearest requester after 'last' wins
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[IW'(idx)]) begin
        win     = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers in bursts.
// Latency: one arbitration bubble per grant; writes are combinational from req in GRANT.
// Backpressure: fifo_full stalls the granted producer indefinitely; no word is offered while full.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int BURST = BURST_DEF,
  localparam int IW    = idx_w(NREQ),
  localparam int CW    = cnt_w(BURST)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    ack,
  input  logic               fifo_full,
  output logic               fifo_wsig,
  output logic [DW-1:0]      fifo_wdata,
  output logic [IW-1:0]      gnt_id,
  output logic               busy
);

  fsm_e          fsm_q, fsm_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;
  logic [IW-1:0] pick_win;
  logic          pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last    (last_q),
    .win     (pick_win),
    .any_req (pick_any)
  );

  // Next-state: arbitrate in IDLE, count words and decide release in GRANT
  always_comb begin
    fsm_d  = fsm_q;
    cur_d  = cur_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    fire   = (fsm_q == GRANT) && req[cur_q] && !fifo_full;
    case (fsm_q)
      IDLE: begin
        if (pick_any) begin
          cur_d = pick_win;
          cnt_d = '0;
          fsm_d = GRANT;
        end
      end
      GRANT: begin
        if (fire) cnt_d = cnt_q + CW'(1);
        // Withdrawal releases even while the FIFO is full
        if ((fire && ((cnt_q == CW'(BURST - 1)) || req_last[cur_q])) || !req[cur_q]) begin
          fsm_d  = IDLE;
          last_d = cur_q;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Write port is driven straight from the granted producer; reset masks the strobe
  always_comb begin
    ack        = '0;
    fifo_wsig  = 1'b0;
    fifo_wdata = req_data[int'(cur_q)*DW +: DW];
    if (rst && fire) begin
      ack[cur_q] = 1'b1;
      fifo_wsig  = 1'b1;
    end
  end

  assign busy   = rst && (fsm_q == GRANT);
  assign gnt_id = cur_q;

  // State registers; reset leaves producer 0 with first priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      cur_q  <= '0;
      last_q <= IW'(NREQ - 1);
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cur_q  <= cur_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
